branch_predictor: RTL and testbench

Dynamic branch predictor sitting directly upstream of the pipeline's IF stage. It supplies the predicted next PC each cycle from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It is trained by branch and jump resolution from the EX stage, and it flags mispredictions with the correct redirect PC. It also keeps branch and mispredict statistics for the debug display.

---
 rtl/branch_predictor.sv | 155 +++++++++++++++
 tb/tb_branch_predictor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB branch predictor with 2-bit counters and statistics
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] pred_npc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        clr_stats,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  logic [1:0]       cnt_q    [N];
  logic             jmp_q    [N];

  logic [31:0] st_br_q, st_br_d, st_mp_q, st_mp_d;

  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0] lk_tag, ex_tag;
  logic             lk_hit, ex_hit, ctl;

  logic             wr_en;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [1:0]       cnt_d;
  logic             jmp_d;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign ctl    = ex_is_branch | ex_is_jump;

  // Fetch-side lookup: purely combinational, sees pre-update contents
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && (jmp_q[lk_idx] || cnt_q[lk_idx][1]);
    pred_target = lk_hit ? target_q[lk_idx] : 32'd0;
    pred_npc    = pred_taken ? pred_target : (if_pc + 32'd4);
  end

  // Resolution check: direction, target or a non-control alias predicted taken
  always_comb begin
    mispredict  = ex_valid && ((ctl && (ex_pred_taken != ex_taken)) ||
                               (ctl && ex_taken && (ex_pred_target != ex_target)) ||
                               (!ctl && ex_pred_taken));
    redirect_pc = (ctl && ex_taken) ? ex_target : (ex_pc + 32'd4);
  end

  // Training: compute the new contents of the EX-indexed entry
  always_comb begin
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    wr_en    = 1'b0;
    valid_d  = valid_q[ex_idx];
    tag_d    = tag_q[ex_idx];
    target_d = target_q[ex_idx];
    cnt_d    = cnt_q[ex_idx];
    jmp_d    = jmp_q[ex_idx];
    if (ex_valid) begin
      if (ctl && ex_hit) begin
        wr_en = 1'b1;
        if (ex_is_jump) begin
          cnt_d    = 2'b11;
          jmp_d    = 1'b1;
          target_d = ex_target;
        end else begin
          jmp_d = 1'b0;
          if (ex_taken) begin
            target_d = ex_target;
            if (cnt_q[ex_idx] != 2'b11) cnt_d = cnt_q[ex_idx] + 2'd1;
          end else if (cnt_q[ex_idx] != 2'b00) begin
            cnt_d = cnt_q[ex_idx] - 2'd1;
          end
        end
      end else if (ctl && ex_taken) begin
        wr_en    = 1'b1;
        valid_d  = 1'b1;
        tag_d    = ex_tag;
        target_d = ex_target;
        cnt_d    = ex_is_jump ? 2'b11 : 2'b10;
        jmp_d    = ex_is_jump;
      end else if (!ctl && ex_hit) begin
        wr_en   = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  // BTB storage: asynchronous clear, single write port from EX
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= valid_d;
      tag_q[ex_idx]    <= tag_d;
      target_q[ex_idx] <= target_d;
      cnt_q[ex_idx]    <= cnt_d;
      jmp_q[ex_idx]    <= jmp_d;
    end
  end

  // Statistics next state: clear wins, otherwise saturating increment
  always_comb begin
    st_br_d = st_br_q;
    st_mp_d = st_mp_q;
    if (clr_stats) begin
      st_br_d = '0;
      st_mp_d = '0;
    end else begin
      if (ex_valid && ctl && (st_br_q != 32'hFFFF_FFFF)) st_br_d = st_br_q + 32'd1;
      if (mispredict && (st_mp_q != 32'hFFFF_FFFF))      st_mp_d = st_mp_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      st_br_q <= '0;
      st_mp_q <= '0;
    end else begin
      st_br_q <= st_br_d;
      st_mp_q <= st_mp_d;
    end
  end

  assign stat_branches    = st_br_q;
  assign stat_mispredicts = st_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target, pred_npc;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_is_branch = 1'b0, ex_is_jump = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        clr_stats = 1'b0;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(.IDX_W(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_npc(pred_npc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .clr_stats(clr_stats), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference model: 16 entries, index = (pc/4) mod 16, tag = pc/64
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_target[16];
  int          m_cnt   [16];
  bit          m_jmp   [16];
  longint      m_br, m_mp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == int'(pc / 64));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_jmp[m_index(pc)] || m_cnt[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_hit(pc) ? m_target[m_index(pc)] : 32'd0;
  endfunction

  function automatic bit m_misp();
    bit c = ex_is_branch || ex_is_jump;
    if (!ex_valid) return 1'b0;
    if (c) return (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target);
    return ex_pred_taken;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1; m_jmp[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic m_update();
    int  i = m_index(ex_pc);
    bit  h = m_hit(ex_pc);
    bit  c = ex_is_branch || ex_is_jump;
    bit  mp = m_misp();
    if (clr_stats) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (ex_valid && c && m_br < 64'hFFFF_FFFF) m_br++;
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
    if (!ex_valid) return;
    if (c && h) begin
      if (ex_is_jump) begin
        m_cnt[i] = 3; m_jmp[i] = 1; m_target[i] = ex_target;
      end else begin
        m_jmp[i] = 0;
        if (ex_taken) begin
          m_target[i] = ex_target;
          m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end
    end else if (c && ex_taken) begin
      m_valid[i] = 1; m_tag[i] = int'(ex_pc / 64); m_target[i] = ex_target;
      m_cnt[i] = ex_is_jump ? 3 : 2; m_jmp[i] = ex_is_jump;
    end else if (!c && h) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic set_ex(input bit v, input bit br, input bit jp, input bit tk,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt, input bit clr);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_taken = tk;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt; clr_stats = clr;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
  endtask

  // Called just after a falling edge with inputs driven: compare all outputs
  task automatic settle_and_check();
    logic [31:0] exp_npc, exp_red;
    #1;
    exp_npc = m_ptaken(if_pc) ? m_ptarget(if_pc) : if_pc + 32'd4;
    exp_red = ((ex_is_branch || ex_is_jump) && ex_taken) ? ex_target : ex_pc + 32'd4;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, m_ptaken(if_pc)});
    check("pred_target", pred_target, m_ptarget(if_pc));
    check("pred_npc", pred_npc, exp_npc);
    check("mispredict", {31'd0, mispredict}, {31'd0, m_misp()});
    if (ex_valid) check("redirect_pc", redirect_pc, exp_red);
    check("stat_branches", stat_branches, m_br[31:0]);
    check("stat_mispredicts", stat_mispredicts, m_mp[31:0]);
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    m_update();
    @(negedge cpu_clk);
  endtask

  task automatic step();
    settle_and_check();
    tick();
  endtask

  initial begin
    logic [31:0] pc, tgt;
    int kind;
    bit use_model;
    m_reset();
    idle();
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // Cold lookup
    if_pc = 32'h40;
    settle_and_check();
    check("cold_npc", pred_npc, 32'h44);
    tick();

    // Cold-miss taken branch
    set_ex(1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0, 0);
    settle_and_check();
    check("cold_misp", {31'd0, mispredict}, 32'd1);
    check("cold_redirect", redirect_pc, 32'h20);
    tick();
    idle();
    settle_and_check();
    check("trained_npc", pred_npc, 32'h20);
    tick();

    // Hysteresis: NT, NT, T
    set_ex(1, 1, 0, 0, 32'h40, 32'h20, 1, 32'h20, 0); step();
    idle(); settle_and_check();
    check("hyst_nt1", {31'd0, pred_taken}, 32'd0);
    tick();
    set_ex(1, 1, 0, 0, 32'h40, 32'h20, 0, 32'h0, 0); step();
    set_ex(1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0, 0); step();
    idle(); settle_and_check();
    check("hyst_t_weak", {31'd0, pred_taken}, 32'd0);
    tick();

    // Jump and aliasing
    set_ex(1, 0, 1, 1, 32'h80, 32'h100, 0, 32'h0, 0); step();
    idle(); if_pc = 32'h80; settle_and_check();
    check("jal_npc", pred_npc, 32'h100);
    tick();
    if_pc = 32'hC0; settle_and_check();
    check("alias_miss_npc", pred_npc, 32'hC4);
    tick();

    // Alias invalidate on 0x40 (retrain first so the entry exists)
    set_ex(1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0, 0); step();
    set_ex(1, 0, 0, 0, 32'h40, 32'h0, 1, 32'h20, 0);
    settle_and_check();
    check("alias_misp", {31'd0, mispredict}, 32'd1);
    check("alias_redirect", redirect_pc, 32'h44);
    tick();
    idle(); if_pc = 32'h40; settle_and_check();
    check("alias_invalid", {31'd0, pred_taken}, 32'd0);
    tick();

    // Statistics: clear, then clear concurrent with mispredict, then invalid slot
    set_ex(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1); step();
    set_ex(1, 1, 0, 0, 32'h200, 32'h0, 0, 32'h0, 0); step();
    set_ex(1, 1, 0, 1, 32'h204, 32'h300, 0, 32'h0, 0); step();
    set_ex(1, 1, 0, 0, 32'h208, 32'h0, 0, 32'h0, 0); step();
    idle(); settle_and_check();
    check("stat3_br", stat_branches, 32'd3);
    check("stat3_mp", stat_mispredicts, 32'd1);
    tick();
    set_ex(1, 1, 0, 1, 32'h20C, 32'h400, 0, 32'h0, 1); step();
    set_ex(0, 1, 0, 1, 32'h210, 32'h400, 0, 32'h0, 0); step();
    idle(); settle_and_check();
    check("clr_br", stat_branches, 32'd0);
    check("clr_mp", stat_mispredicts, 32'd0);
    tick();

    // Randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 600; n++) begin
      pc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      tgt  = 32'($urandom_range(0, 255)) << 2;
      kind = $urandom_range(0, 3);
      use_model = ($urandom_range(0, 9) < 7);
      ex_valid       = ($urandom_range(0, 9) < 8);
      ex_pc          = pc;
      ex_is_branch   = (kind == 1 || kind == 2);
      ex_is_jump     = (kind == 3);
      ex_taken       = (kind == 3) ? 1'b1 : (kind == 0 ? 1'b0 : 1'($urandom));
      ex_target      = tgt;
      ex_pred_taken  = use_model ? m_ptaken(pc) : 1'($urandom_range(0, 3) == 0);
      ex_pred_target = use_model ? m_ptarget(pc) : tgt;
      clr_stats      = ($urandom_range(0, 49) == 0);
      if_pc          = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      step();
    end

    // Asynchronous reset mid-operation
    set_ex(1, 0, 1, 1, 32'h80, 32'h100, 0, 32'h0, 0); step();
    idle(); if_pc = 32'h80; settle_and_check();
    #2 cpu_rstn = 1'b0;
    #1;
    m_reset();
    check("async_rst_taken", {31'd0, pred_taken}, 32'd0);
    check("async_rst_npc", pred_npc, 32'h84);
    check("async_rst_br", stat_branches, 32'd0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    settle_and_check();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
